if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Fetch stage of the pipelined MIPS core: holds the program counter, drives the instruction-memory address, and registers the fetched instruction into the IF/ID pipeline register.
- Decodes the registered instruction into the fields consumed by the ID/EX register: RsD, RtD, RdD and sign-extended SIMM.
- Handles hazard-unit stall and flush, branch redirect from the later stage, and jump redirect resolved locally in decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble on flush or reset.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- CLR  input  1  synchronous active-low reset.
- StallF  input  1  hold PC this cycle.
- StallD  input  1  hold the IF/ID register this cycle.
- FlushD  input  1  load a bubble into IF/ID this cycle.
- PCSrc  input  1  taken-branch redirect from the later stage.
- PCBranch  input  32  branch target, valid when PCSrc=1.
- Instr_in  input  32  instruction-memory read data for the current PCF (combinational memory).
- PCF  output  32  current fetch address, registered.
- InstrD  output  32  registered instruction.
- PCPlus4D  output  32  registered PC+4 of InstrD.
- ValidD  output  1  InstrD is a real instruction (0 = bubble).
- RsD  output  5  InstrD[25:21], combinational from InstrD.
- RtD  output  5  InstrD[20:16], combinational from InstrD.
- RdD  output  5  InstrD[15:11], combinational from InstrD.
- SIMM  output  32  InstrD[15:0] sign-extended, combinational from InstrD.
- JumpD  output  1  jump taken this cycle (see below).

Behaviour:
- Reset (CLR=0 at posedge): PCF=RESET_PC, InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0. With the default NOP, RsD=RtD=RdD=0, SIMM=0 and JumpD=0. Reset overrides every other input, including mid-stall and mid-redirect.
- PCPlus4F = PCF + 32'd4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- JumpD = ValidD & (InstrD[31:26]==6'b000010) & ~StallD.
- JumpTarget = {PCPlus4D[31:28], InstrD[25:0], 2'b00}.
- PC next-state priority, first match wins:
  1. Reset.
  2. PCSrc → PCBranch.
  3. JumpD → JumpTarget.
  4. StallF → hold.
  5. Otherwise → PCPlus4F.
- Redirect overrides StallF: the instructions being stalled are wrong-path.
- PCBranch[1:0] is stored as given; no alignment check.
- IF/ID next-state priority, first match wins:
  1. Reset.
  2. FlushD | PCSrc | JumpD → bubble (InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0).
  3. StallD → hold all three registers.
  4. Otherwise → InstrD=Instr_in, PCPlus4D=PCPlus4F, ValidD=1.
- Flush beats stall when both are asserted.
- There is no branch delay slot: a taken jump or branch kills the instruction fetched in the same cycle.
- Latency: an instruction presented on Instr_in at cycle n appears on InstrD at cycle n+1 if not stalled or flushed. A redirect asserted at cycle n gives PCF = target at cycle n+1.
- StallF=1 with StallD=0 and no flush: IF/ID still loads Instr_in, which re-fetches the same PC. Legal; the hazard unit is responsible for avoiding this combination.
- Outputs change only at posedge CLK. RsD, RtD, RdD, SIMM and JumpD are pure functions of registered state (plus StallD for JumpD).

Optional Feature:
- Macro: IF_ID_STALL_COUNT_EN.
- Defined:
  - Adds output StallCount [15:0] and output FlushCount [15:0].
  - StallCount increments each posedge with StallF=1. FlushCount increments each posedge on which IF/ID loads a bubble due to FlushD|PCSrc|JumpD.
  - Both saturate at 16'hFFFF and reset to 0 on CLR=0.
  - Counting never alters pipeline behaviour.
- Undefined: neither port nor counter logic exists.

Test Plan:
- Reset then free-run, Instr_in = 32'h2008_0005 constant, 3 cycles → PCF 0→4→8→C; InstrD=32'h2008_0005, PCPlus4D=4 then 8; ValidD=1; RtD=8; SIMM=32'h0000_0005.
- Instr_in=32'h2009_FFFF loaded → SIMM=32'hFFFF_FFFF, RsD=0, RtD=9.
- StallF=StallD=1 for 2 cycles at PCF=8 → PCF stays 8; InstrD/PCPlus4D/ValidD hold. Release → PCF=C next cycle.
- PCSrc=1, PCBranch=32'h0000_0100, StallF=1 simultaneously → PCF=32'h100 next cycle; ValidD=0, InstrD=0. With IF_ID_STALL_COUNT_EN defined, FlushCount +1.
- InstrD=32'h0800_0040 (j), PCPlus4D=32'h1000_0008, StallD=0 → JumpD=1; PCF=32'h1000_0100 next cycle; ValidD=0. Same case with StallD=1 → JumpD=0, PC held.
- PCF forced to 32'hFFFF_FFFC via PCBranch, then free-run → PCF wraps to 0. Drive CLR=0 mid-stall → PCF=RESET_PC and ValidD=0 next posedge.

Source files
------------

// File: rtl/if_id_stage_if.sv
// Fetch-to-decode bundle of the MIPS IF/ID stage: hazard controls, redirect, fetch data and decode fields.
// Optional counters appear when IF_ID_STALL_COUNT_EN is defined.
interface if_id_stage_if;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        PCSrc;
  logic [31:0] PCBranch;
  logic [31:0] Instr_in;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic [4:0]  RsD;
  logic [4:0]  RtD;
  logic [4:0]  RdD;
  logic [31:0] SIMM;
  logic        JumpD;

`ifdef IF_ID_STALL_COUNT_EN
  logic [15:0] StallCount;
  logic [15:0] FlushCount;

  modport slave (
    input  StallF, StallD, FlushD, PCSrc, PCBranch, Instr_in,
    output PCF, InstrD, PCPlus4D, ValidD, RsD, RtD, RdD, SIMM, JumpD,
    output StallCount, FlushCount
  );

  modport master (
    output StallF, StallD, FlushD, PCSrc, PCBranch, Instr_in,
    input  PCF, InstrD, PCPlus4D, ValidD, RsD, RtD, RdD, SIMM, JumpD,
    input  StallCount, FlushCount
  );
`else
  modport slave (
    input  StallF, StallD, FlushD, PCSrc, PCBranch, Instr_in,
    output PCF, InstrD, PCPlus4D, ValidD, RsD, RtD, RdD, SIMM, JumpD
  );

  modport master (
    output StallF, StallD, FlushD, PCSrc, PCBranch, Instr_in,
    input  PCF, InstrD, PCPlus4D, ValidD, RsD, RtD, RdD, SIMM, JumpD
  );
`endif
endinterface

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register of the pipelined MIPS core, with local jump resolution.
// Define IF_ID_STALL_COUNT_EN to add saturating StallCount/FlushCount event counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic          CLK,
  input logic          CLR,
  if_id_stage_if.slave bus
);

  localparam logic [5:0] OP_J = 6'b000010;

  logic [31:0] pcf_r;
  logic [31:0] instr_d_r;
  logic [31:0] pc_plus4_d_r;
  logic        valid_d_r;

  logic [31:0] pc_plus4_f_s;
  logic [31:0] jump_target_s;
  logic [31:0] pc_next_s;
  logic        jump_d_s;
  logic        bubble_s;

  assign pc_plus4_f_s  = pcf_r + 32'd4;
  assign jump_d_s      = valid_d_r & (instr_d_r[31:26] == OP_J) & ~bus.StallD;
  assign jump_target_s = {pc_plus4_d_r[31:28], instr_d_r[25:0], 2'b00};
  // A taken redirect kills the instruction fetched alongside it (no delay slot).
  assign bubble_s      = bus.FlushD | bus.PCSrc | jump_d_s;

  // PC next-state: redirects win over StallF since stalled fetches are wrong-path.
  always_comb begin
    pc_next_s = pc_plus4_f_s;
    if (bus.PCSrc) begin
      pc_next_s = bus.PCBranch;
    end else if (jump_d_s) begin
      pc_next_s = jump_target_s;
    end else if (bus.StallF) begin
      pc_next_s = pcf_r;
    end else begin
      pc_next_s = pc_plus4_f_s;
    end
  end

  // Program counter register.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      pcf_r <= RESET_PC;
    end else begin
      pcf_r <= pc_next_s;
    end
  end

  // IF/ID pipeline register: bubble beats stall, stall beats load.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      instr_d_r    <= NOP_INSTR;
      pc_plus4_d_r <= 32'h0000_0000;
      valid_d_r    <= 1'b0;
    end else if (bubble_s) begin
      instr_d_r    <= NOP_INSTR;
      pc_plus4_d_r <= 32'h0000_0000;
      valid_d_r    <= 1'b0;
    end else if (bus.StallD) begin
      instr_d_r    <= instr_d_r;
      pc_plus4_d_r <= pc_plus4_d_r;
      valid_d_r    <= valid_d_r;
    end else begin
      instr_d_r    <= bus.Instr_in;
      pc_plus4_d_r <= pc_plus4_f_s;
      valid_d_r    <= 1'b1;
    end
  end

  assign bus.PCF      = pcf_r;
  assign bus.InstrD   = instr_d_r;
  assign bus.PCPlus4D = pc_plus4_d_r;
  assign bus.ValidD   = valid_d_r;
  assign bus.RsD      = instr_d_r[25:21];
  assign bus.RtD      = instr_d_r[20:16];
  assign bus.RdD      = instr_d_r[15:11];
  assign bus.SIMM     = {{16{instr_d_r[15]}}, instr_d_r[15:0]};
  assign bus.JumpD    = jump_d_s;

`ifdef IF_ID_STALL_COUNT_EN
  logic [15:0] stall_count_r;
  logic [15:0] flush_count_r;

  // Saturating event counters; observation only.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      stall_count_r <= 16'h0000;
      flush_count_r <= 16'h0000;
    end else begin
      if (bus.StallF && (stall_count_r != 16'hFFFF)) begin
        stall_count_r <= stall_count_r + 16'd1;
      end else begin
        stall_count_r <= stall_count_r;
      end
      if (bubble_s && (flush_count_r != 16'hFFFF)) begin
        flush_count_r <= flush_count_r + 16'd1;
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

  assign bus.StallCount = stall_count_r;
  assign bus.FlushCount = flush_count_r;
`else
  // Counters not built in this configuration.
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed vector table, hand sequences, then random traffic vs a reference model.
module tb_if_id_stage;

  logic CLK;
  logic CLR;

  if_id_stage_if bus ();

  if_id_stage dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ctl = {clr, stallf, stalld, flushd, pcsrc}
  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] pb;
    logic [31:0] ins;
    logic        ej;
    logic [31:0] epc;
    logic [31:0] eins;
    logic [31:0] epc4;
    logic        ev;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] pc4;
    logic        v;
    logic [15:0] sc;
    logic [15:0] fc;
  } st_t;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  st_t  m;
  vec_t tbl [24];

  function automatic vec_t mk(input logic [4:0] ctl, input logic [31:0] pb, input logic [31:0] ins,
                              input logic ej, input logic [31:0] epc, input logic [31:0] eins,
                              input logic [31:0] epc4, input logic ev);
    vec_t r;
    r.ctl = ctl; r.pb = pb; r.ins = ins; r.ej = ej;
    r.epc = epc; r.eins = eins; r.epc4 = epc4; r.ev = ev;
    return r;
  endfunction

  // Reference behaviour written straight from the stage's priority rules.
  function automatic st_t model_next(input st_t s, input vec_t v, output logic jmp);
    st_t n;
    logic clr, sf, sd, fd, ps;
    n = s;
    {clr, sf, sd, fd, ps} = v.ctl;
    jmp = s.v && (s.ins[31:26] == 6'b000010) && !sd;
    if (!clr) begin
      n.pc = 32'h0000_0000; n.ins = 32'h0000_0000; n.pc4 = 32'h0000_0000; n.v = 1'b0;
      n.sc = 16'h0000; n.fc = 16'h0000;
    end else begin
      if (ps)        n.pc = v.pb;
      else if (jmp)  n.pc = (s.pc4 & 32'hF000_0000) | ({6'd0, s.ins[25:0]} * 32'd4);
      else if (!sf)  n.pc = s.pc + 32'd4;
      if (fd || ps || jmp) begin
        n.ins = 32'h0000_0000; n.pc4 = 32'h0000_0000; n.v = 1'b0;
        if (s.fc != 16'hFFFF) n.fc = s.fc + 16'd1;
      end else if (!sd) begin
        n.ins = v.ins; n.pc4 = s.pc + 32'd4; n.v = 1'b1;
      end
      if (sf && (s.sc != 16'hFFFF)) n.sc = s.sc + 16'd1;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic run_vec(input vec_t v);
    logic j;
    st_t  nx;
    logic [31:0] e;
    @(negedge CLK);
    {CLR, bus.StallF, bus.StallD, bus.FlushD, bus.PCSrc} = v.ctl;
    bus.PCBranch = v.pb;
    bus.Instr_in = v.ins;
    #1;
    nx = model_next(m, v, j);
    chk("JumpD", {31'd0, bus.JumpD}, {31'd0, v.ej});
    @(posedge CLK);
    #1;
    m = nx;
    e = v.eins;
    chk("PCF",      bus.PCF,      v.epc);
    chk("InstrD",   bus.InstrD,   e);
    chk("PCPlus4D", bus.PCPlus4D, v.epc4);
    chk("ValidD",   {31'd0, bus.ValidD}, {31'd0, v.ev});
    chk("RsD",      {27'd0, bus.RsD}, {27'd0, e[25:21]});
    chk("RtD",      {27'd0, bus.RtD}, {27'd0, e[20:16]});
    chk("RdD",      {27'd0, bus.RdD}, {27'd0, e[15:11]});
    chk("SIMM",     bus.SIMM, {{16{e[15]}}, e[15:0]});
`ifdef IF_ID_STALL_COUNT_EN
    chk("StallCount", {16'd0, bus.StallCount}, {16'd0, m.sc});
    chk("FlushCount", {16'd0, bus.FlushCount}, {16'd0, m.fc});
`endif
  endtask

  initial begin
    logic [31:0] r_ins;
    logic        jd;
    vec_t        rv;
    st_t         pn;

    tbl[0]  = mk(5'b00000, 32'h0,         32'h2008_0005, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0);
    tbl[1]  = mk(5'b10000, 32'h0,         32'h2008_0005, 1'b0, 32'h4,         32'h2008_0005, 32'h4,         1'b1);
    tbl[2]  = mk(5'b10000, 32'h0,         32'h2008_0005, 1'b0, 32'h8,         32'h2008_0005, 32'h8,         1'b1);
    tbl[3]  = mk(5'b11100, 32'h0,         32'h2009_FFFF, 1'b0, 32'h8,         32'h2008_0005, 32'h8,         1'b1);
    tbl[4]  = mk(5'b11100, 32'h0,         32'h2009_FFFF, 1'b0, 32'h8,         32'h2008_0005, 32'h8,         1'b1);
    tbl[5]  = mk(5'b10000, 32'h0,         32'h2009_FFFF, 1'b0, 32'hC,         32'h2009_FFFF, 32'hC,         1'b1);
    tbl[6]  = mk(5'b11001, 32'h1000_0004, 32'h2008_0005, 1'b0, 32'h1000_0004, 32'h0,         32'h0,         1'b0);
    tbl[7]  = mk(5'b10000, 32'h0,         32'h0800_0040, 1'b0, 32'h1000_0008, 32'h0800_0040, 32'h1000_0008, 1'b1);
    tbl[8]  = mk(5'b11100, 32'h0,         32'h2008_0005, 1'b0, 32'h1000_0008, 32'h0800_0040, 32'h1000_0008, 1'b1);
    tbl[9]  = mk(5'b10000, 32'h0,         32'h2008_0005, 1'b1, 32'h1000_0100, 32'h0,         32'h0,         1'b0);
    tbl[10] = mk(5'b10000, 32'h0,         32'h2008_0005, 1'b0, 32'h1000_0104, 32'h2008_0005, 32'h1000_0104, 1'b1);
    tbl[11] = mk(5'b10110, 32'h0,         32'h2008_0005, 1'b0, 32'h1000_0108, 32'h0,         32'h0,         1'b0);
    tbl[12] = mk(5'b10001, 32'hFFFF_FFFC, 32'h2008_0005, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b0);
    tbl[13] = mk(5'b10000, 32'h0,         32'h2009_FFFF, 1'b0, 32'h0,         32'h2009_FFFF, 32'h0,         1'b1);
    tbl[14] = mk(5'b10000, 32'h0,         32'h2008_0005, 1'b0, 32'h4,         32'h2008_0005, 32'h4,         1'b1);
    tbl[15] = mk(5'b11100, 32'h0,         32'h2009_FFFF, 1'b0, 32'h4,         32'h2008_0005, 32'h4,         1'b1);
    tbl[16] = mk(5'b01101, 32'h200,       32'h2009_FFFF, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0);
    tbl[17] = mk(5'b11000, 32'h0,         32'h2008_0005, 1'b0, 32'h0,         32'h2008_0005, 32'h4,         1'b1);
    tbl[18] = mk(5'b10001, 32'h102,       32'h2008_0005, 1'b0, 32'h102,       32'h0,         32'h0,         1'b0);
    tbl[19] = mk(5'b10000, 32'h0,         32'h2009_FFFF, 1'b0, 32'h106,       32'h2009_FFFF, 32'h106,       1'b1);
    tbl[20] = mk(5'b10000, 32'h0,         32'h0800_0040, 1'b0, 32'h10A,       32'h0800_0040, 32'h10A,       1'b1);
    tbl[21] = mk(5'b10001, 32'h300,       32'h2008_0005, 1'b1, 32'h300,       32'h0,         32'h0,         1'b0);
    tbl[22] = mk(5'b10000, 32'h0,         32'h0800_0040, 1'b0, 32'h304,       32'h0800_0040, 32'h304,       1'b1);
    tbl[23] = mk(5'b11000, 32'h0,         32'h2008_0005, 1'b1, 32'h100,       32'h0,         32'h0,         1'b0);

    CLR = 1'b0;
    bus.StallF = 1'b0; bus.StallD = 1'b0; bus.FlushD = 1'b0; bus.PCSrc = 1'b0;
    bus.PCBranch = 32'h0; bus.Instr_in = 32'h0;
    repeat (2) @(posedge CLK);
    m = '{pc: 32'h0, ins: 32'h0, pc4: 32'h0, v: 1'b0, sc: 16'h0, fc: 16'h0};

    for (int i = 0; i < 24; i++) run_vec(tbl[i]);

    // Hand sequence: jump sitting in decode while a reset arrives mid-stall.
    run_vec(mk(5'b10000, 32'h0,   32'h0800_0040, 1'b0, 32'h104, 32'h0800_0040, 32'h104, 1'b1));
    run_vec(mk(5'b01100, 32'h0,   32'h2008_0005, 1'b0, 32'h0,   32'h0,         32'h0,   1'b0));
    run_vec(mk(5'b10000, 32'h0,   32'h2008_0005, 1'b0, 32'h4,   32'h2008_0005, 32'h4,   1'b1));

    for (int k = 0; k < 500; k++) begin
      r_ins = $urandom;
      if ($urandom_range(0, 3) == 0) r_ins[31:26] = 6'b000010;
      rv.ctl[4] = ($urandom_range(0, 40) != 0);
      rv.ctl[3] = ($urandom_range(0, 3) == 0);
      rv.ctl[2] = ($urandom_range(0, 3) == 0);
      rv.ctl[1] = ($urandom_range(0, 7) == 0);
      rv.ctl[0] = ($urandom_range(0, 7) == 0);
      rv.pb  = $urandom;
      rv.ins = r_ins;
      pn = model_next(m, rv, jd);
      rv.ej = jd; rv.epc = pn.pc; rv.eins = pn.ins; rv.epc4 = pn.pc4; rv.ev = pn.v;
      run_vec(rv);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
